// File: rtl/seq_match_monitor.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_monitor
// Brief    : Recognizer for "a ##[LO:HI] b" with per-attempt tracking and
//            saturating match / fail / attempt counters.
// Revision : 1.0
// ============================================================================
module seq_match_monitor #(
   parameter int LO    = 1,
   parameter int HI    = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             a,
   input  logic             b,
   output logic             match,
   output logic [5:0]       match_num,
   output logic             fail,
   output logic             active,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] attempt_cnt
);

   logic [HI:1]      r_pend;
   logic             r_match;
   logic [5:0]       r_match_num;
   logic             r_fail;
   logic             r_active;
   logic [CNT_W-1:0] r_match_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [CNT_W-1:0] r_attempt_cnt;

   logic [HI:1]      w_hit;
   logic [HI:1]      w_next_pend;
   logic [5:0]       w_hit_num;
   logic             w_fail;
   logic             w_start;

   assign w_start = a & en;

   // Bit k is the attempt of age k; only ages inside the window may complete.
   generate
      for (genvar k = 1; k <= HI; k++) begin : g_hit
         localparam logic c_ELIG = (k >= LO) ? 1'b1 : 1'b0;
         assign w_hit[k] = r_pend[k] & b & c_ELIG;
      end
      for (genvar k = 1; k < HI; k++) begin : g_age
         assign w_next_pend[k+1] = r_pend[k] & ~w_hit[k];
      end
   endgenerate

   assign w_next_pend[1] = w_start;
   assign w_fail         = r_pend[HI] & ~w_hit[HI];

   always_comb begin
      w_hit_num = '0;
      for (int k = 1; k <= HI; k++) begin
         w_hit_num = w_hit_num + {5'd0, w_hit[k]};
      end
   end

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x,
                                                input logic [5:0]       inc);
      logic [CNT_W+6:0] s;
      s = {7'd0, x} + {{(CNT_W+1){1'b0}}, inc};
      if (s > {7'd0, {CNT_W{1'b1}}}) begin
         return {CNT_W{1'b1}};
      end
      return s[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend        <= '0;
         r_match       <= 1'b0;
         r_match_num   <= '0;
         r_fail        <= 1'b0;
         r_active      <= 1'b0;
         r_match_cnt   <= '0;
         r_fail_cnt    <= '0;
         r_attempt_cnt <= '0;
      end else if (clr) begin
         r_pend        <= '0;
         r_match       <= 1'b0;
         r_match_num   <= '0;
         r_fail        <= 1'b0;
         r_active      <= 1'b0;
         r_match_cnt   <= '0;
         r_fail_cnt    <= '0;
         r_attempt_cnt <= '0;
      end else begin
         r_pend        <= w_next_pend;
         r_match       <= |w_hit;
         r_match_num   <= w_hit_num;
         r_fail        <= w_fail;
         r_active      <= |w_next_pend;
         r_match_cnt   <= sat_add(r_match_cnt, w_hit_num);
         r_fail_cnt    <= sat_add(r_fail_cnt, {5'd0, w_fail});
         r_attempt_cnt <= sat_add(r_attempt_cnt, {5'd0, w_start});
      end
   end

   assign match       = r_match;
   assign match_num   = r_match_num;
   assign fail        = r_fail;
   assign active      = r_active;
   assign match_cnt   = r_match_cnt;
   assign fail_cnt    = r_fail_cnt;
   assign attempt_cnt = r_attempt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_match_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_match_monitor
// Brief    : Table-driven scoreboard bench for seq_match_monitor (two configs).
// Revision : 1.0
// ============================================================================
module tb_seq_match_monitor;

   logic clk = 1'b0;
   logic rst, en, clr, a, b;

   logic        m0, f0, act0, m1, f1, act1;
   logic [5:0]  n0, n1;
   logic [15:0] mc0, fc0, ac0;
   logic [1:0]  mc1, fc1, ac1;

   always #5 clk = ~clk;

   seq_match_monitor #(.LO(1), .HI(5), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
      .match(m0), .match_num(n0), .fail(f0), .active(act0),
      .match_cnt(mc0), .fail_cnt(fc0), .attempt_cnt(ac0)
   );

   seq_match_monitor #(.LO(2), .HI(5), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
      .match(m1), .match_num(n1), .fail(f1), .active(act1),
      .match_cnt(mc1), .fail_cnt(fc1), .attempt_cnt(ac1)
   );

   typedef struct {
      logic a, b, en, clr;
      int   m0, n0, f0, act0;
      int   m1, n1, f1, act1;
   } vec_t;

   vec_t tv[$];
   vec_t sbq[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   int   row      = 0;
   // Expected counter values, rebuilt from the table's expected pulses.
   int   em0 = 0, ef0 = 0, ea0 = 0, em1 = 0, ef1 = 0, ea1 = 0;

   function automatic vec_t V(input logic a_, b_, en_, clr_,
                              input int m0_, n0_, f0_, act0_,
                              input int m1_, n1_, f1_, act1_);
      vec_t v;
      v.a = a_; v.b = b_; v.en = en_; v.clr = clr_;
      v.m0 = m0_; v.n0 = n0_; v.f0 = f0_; v.act0 = act0_;
      v.m1 = m1_; v.n1 = n1_; v.f1 = f1_; v.act1 = act1_;
      return v;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] got, input int exp);
      n_checks++;
      if (got !== exp[31:0]) begin
         n_fails++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, got, exp);
      end
   endtask

   task automatic zero_model();
      em0 = 0; ef0 = 0; ea0 = 0; em1 = 0; ef1 = 0; ea1 = 0;
   endtask

   // Called at a negedge: drive, push expectation, sample #1 after the edge.
   task automatic drive(input vec_t v);
      vec_t e;
      a = v.a; b = v.b; en = v.en; clr = v.clr;
      sbq.push_back(v);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      if (e.clr) begin
         zero_model();
      end else begin
         em0 = sat(em0 + e.n0, 65535);
         ef0 = sat(ef0 + e.f0, 65535);
         ea0 = sat(ea0 + int'(e.a & e.en), 65535);
         em1 = sat(em1 + e.n1, 3);
         ef1 = sat(ef1 + e.f1, 3);
         ea1 = sat(ea1 + int'(e.a & e.en), 3);
      end
      chk("match0", row, m0, e.m0);
      chk("num0", row, n0, e.n0);
      chk("fail0", row, f0, e.f0);
      chk("active0", row, act0, e.act0);
      chk("mcnt0", row, mc0, em0);
      chk("fcnt0", row, fc0, ef0);
      chk("acnt0", row, ac0, ea0);
      chk("match1", row, m1, e.m1);
      chk("num1", row, n1, e.n1);
      chk("fail1", row, f1, e.f1);
      chk("active1", row, act1, e.act1);
      chk("mcnt1", row, mc1, em1);
      chk("fcnt1", row, fc1, ef1);
      chk("acnt1", row, ac1, ea1);
      row++;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0;

      // Columns: a b en clr | dut0 m n f act | dut1(LO=2,CNT_W=2) m n f act
      tv.push_back(V(0,0,1,1, 0,0,0,0, 0,0,0,0));
      tv.push_back(V(1,0,1,0, 0,0,0,1, 0,0,0,1));   // single match
      tv.push_back(V(0,1,1,0, 1,1,0,0, 0,0,0,1));
      tv.push_back(V(0,0,1,0, 0,0,0,0, 0,0,0,1));
      tv.push_back(V(0,0,1,1, 0,0,0,0, 0,0,0,0));
      tv.push_back(V(1,0,1,0, 0,0,0,1, 0,0,0,1));   // match at age HI
      for (int i = 0; i < 4; i++) tv.push_back(V(0,0,1,0, 0,0,0,1, 0,0,0,1));
      tv.push_back(V(0,1,1,0, 1,1,0,0, 1,1,0,0));
      tv.push_back(V(0,0,1,0, 0,0,0,0, 0,0,0,0));
      tv.push_back(V(1,0,1,0, 0,0,0,1, 0,0,0,1));   // timeout
      for (int i = 0; i < 4; i++) tv.push_back(V(0,0,1,0, 0,0,0,1, 0,0,0,1));
      tv.push_back(V(0,0,1,0, 0,0,1,0, 0,0,1,0));
      tv.push_back(V(0,1,1,0, 0,0,0,0, 0,0,0,0));
      tv.push_back(V(1,0,1,0, 0,0,0,1, 0,0,0,1));   // LO=2 lower edge
      tv.push_back(V(0,1,1,0, 1,1,0,0, 0,0,0,1));
      tv.push_back(V(0,1,1,0, 0,0,0,0, 1,1,0,0));
      tv.push_back(V(0,0,1,1, 0,0,0,0, 0,0,0,0));
      tv.push_back(V(1,0,1,0, 0,0,0,1, 0,0,0,1));   // overlap
      tv.push_back(V(1,0,1,0, 0,0,0,1, 0,0,0,1));
      tv.push_back(V(0,0,1,0, 0,0,0,1, 0,0,0,1));
      tv.push_back(V(0,1,1,0, 1,2,0,0, 1,2,0,0));
      tv.push_back(V(0,1,1,0, 0,0,0,0, 0,0,0,0));
      tv.push_back(V(1,0,1,0, 0,0,0,1, 0,0,0,1));   // simultaneous a and b
      tv.push_back(V(0,0,1,0, 0,0,0,1, 0,0,0,1));
      tv.push_back(V(1,1,1,0, 1,1,0,1, 1,1,0,1));
      tv.push_back(V(0,1,1,0, 1,1,0,0, 0,0,0,1));
      tv.push_back(V(0,0,1,1, 0,0,0,0, 0,0,0,0));
      tv.push_back(V(1,0,0,0, 0,0,0,0, 0,0,0,0));   // enable gating
      tv.push_back(V(0,1,0,0, 0,0,0,0, 0,0,0,0));
      tv.push_back(V(1,0,1,0, 0,0,0,1, 0,0,0,1));
      tv.push_back(V(0,0,0,0, 0,0,0,1, 0,0,0,1));
      tv.push_back(V(0,1,0,0, 1,1,0,0, 1,1,0,0));
      tv.push_back(V(1,0,1,1, 0,0,0,0, 0,0,0,0));   // a ignored under clr
      tv.push_back(V(0,1,1,0, 0,0,0,0, 0,0,0,0));

      @(negedge clk);
      chk("rst_match0", 0, m0, 0);
      chk("rst_num0", 0, n0, 0);
      chk("rst_active0", 0, act0, 0);
      chk("rst_mcnt0", 0, mc0, 0);
      chk("rst_acnt1", 0, ac1, 0);
      rst = 1'b0;

      foreach (tv[i]) drive(tv[i]);

      // Asynchronous reset in the middle of an attempt.
      drive(V(0,0,1,1, 0,0,0,0, 0,0,0,0));
      drive(V(1,0,1,0, 0,0,0,1, 0,0,0,1));
      drive(V(0,0,1,0, 0,0,0,1, 0,0,0,1));
      #1 rst = 1'b1;
      #1;
      chk("arst_active0", 0, act0, 0);
      chk("arst_acnt0", 0, ac0, 0);
      chk("arst_active1", 0, act1, 0);
      #1 rst = 1'b0;
      zero_model();
      drive(V(0,0,1,0, 0,0,0,0, 0,0,0,0));
      drive(V(0,1,1,0, 0,0,0,0, 0,0,0,0));

      // Synchronous clear in the middle of an attempt.
      drive(V(1,0,1,0, 0,0,0,1, 0,0,0,1));
      drive(V(0,0,1,0, 0,0,0,1, 0,0,0,1));
      drive(V(0,0,1,1, 0,0,0,0, 0,0,0,0));
      drive(V(0,1,1,0, 0,0,0,0, 0,0,0,0));
      chk("clr_acnt0", 0, ac0, 0);

      // Five isolated matches: the 2-bit counter holds at 3.
      for (int i = 0; i < 5; i++) begin
         drive(V(1,0,1,0, 0,0,0,1, 0,0,0,1));
         drive(V(0,0,1,0, 0,0,0,1, 0,0,0,1));
         drive(V(0,1,1,0, 1,1,0,0, 1,1,0,0));
         drive(V(0,0,1,0, 0,0,0,0, 0,0,0,0));
      end
      chk("sat_mcnt1", 0, mc1, 3);
      chk("sat_mcnt0", 0, mc0, 5);
      chk("sbq_empty", 0, sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
